// File: rtl/mem_bridge.sv
// Bridge between the multicycle controller and a variable-latency unified memory.
// Converts single-cycle strobes into a req/ack transaction, stalls the controller, owns IR and MDR.
module mem_bridge #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic              IorD,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              bus_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [DATA_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0]   r_instr, w_instr_nxt;
    logic [DATA_W-1:0]   r_mdr, w_mdr_nxt;
    logic                r_bus_error, w_bus_error_nxt;
    logic                r_dest, w_dest_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   w_addr_sel;
    logic                w_stall;

    assign w_addr_sel = IorD ? alu_out : pc;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_instr     <= '0;
            r_mdr       <= '0;
            r_bus_error <= 1'b0;
            r_dest      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_instr     <= w_instr_nxt;
            r_mdr       <= w_mdr_nxt;
            r_bus_error <= w_bus_error_nxt;
            r_dest      <= w_dest_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Next-state, next-register values and stall decode
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_instr_nxt     = r_instr;
        w_mdr_nxt       = r_mdr;
        w_bus_error_nxt = r_bus_error;
        w_dest_nxt      = r_dest;
        w_cnt_nxt       = r_cnt;
        w_stall         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_stall = MemRead | MemWrite;
                if (MemRead ^ MemWrite) begin
                    if (w_addr_sel[1:0] != 2'b00) begin
                        w_state_nxt     = S_ERR;
                        w_bus_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_REQ;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = MemWrite;
                        w_mem_addr_nxt  = w_addr_sel;
                        w_mem_wdata_nxt = wdata;
                        w_dest_nxt      = IRWrite;
                        w_cnt_nxt       = '0;
                    end
                end else if (MemRead & MemWrite) begin
                    w_state_nxt     = S_ERR;
                    w_bus_error_nxt = 1'b1;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                // An ack in the final timeout cycle still completes the access
                if (mem_ack) begin
                    if (!r_mem_we) begin
                        if (r_dest) begin
                            w_instr_nxt = mem_rdata;
                        end else begin
                            w_mdr_nxt = mem_rdata;
                        end
                    end
                    w_state_nxt   = S_DONE;
                    w_mem_req_nxt = 1'b0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt     = S_ERR;
                    w_mem_req_nxt   = 1'b0;
                    w_bus_error_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            S_ERR: begin
                w_stall = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is asserted
    assign stall     = rst & w_stall;
    assign instr     = r_instr;
    assign mdr       = r_mdr;
    assign bus_error = r_bus_error;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
